sm4_tau_engine: RTL and testbench
=================================

SM4_TAU_ENGINE -- requirements
Module: sm4_tau_engine

Interface
REQ-001 SHALL have parameter WORDS, default 1, meaning number of 32-bit words substituted per transaction (legal 1..4).
REQ-002 SHALL have parameter N_SBOX, default 4, meaning number of physical 8-bit S-box instances (legal 1, 2, 4 or 8, dividing 4*WORDS).
REQ-003 SHALL have port clk_i  input  1  system clock, all state on rising edge.
REQ-004 SHALL have port rst_i  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port in_valid_i  input  1  input transaction valid.
REQ-006 SHALL have port in_ready_o  output  1  engine can accept input.
REQ-007 SHALL have port X_i  input  32*WORDS  input words; byte 0 is the most-significant byte of word 0.
REQ-008 SHALL have port out_valid_o  output  1  result valid.
REQ-009 SHALL have port out_ready_i  input  1  downstream accepts result.
REQ-010 SHALL have port Y_o  output  32*WORDS  substituted words, same byte ordering as X_i.

Function
REQ-011 SHALL apply the SM4 S-box (GB/T 32907-2016) independently to every byte of X_i: Y byte k = Sbox(X byte k).
REQ-012 SHALL define CYC = 4*WORDS/N_SBOX and use a byte-group counter of width max(1, clog2(CYC)).
REQ-013 SHALL implement FSM states IDLE, BUSY and DONE.
REQ-014 SHALL, in IDLE, drive in_ready_o=1 and, on in_valid_i&in_ready_o, capture X_i into a working register, clear the counter, and enter BUSY.
REQ-015 SHALL, in each BUSY cycle, replace working bytes cnt*N_SBOX .. cnt*N_SBOX+N_SBOX-1 with their S-box outputs at the clock edge and then increment cnt.
REQ-016 SHALL leave BUSY for DONE at the edge that processes the last group (cnt=CYC-1); when CYC=1 BUSY lasts exactly one cycle.
REQ-017 SHALL assert out_valid_o only in DONE, with Y_o driven from the working register and stable until handshake.
REQ-018 SHALL treat latency as CYC+1 cycles from accept edge to first cycle with out_valid_o=1.
REQ-019 SHALL, in DONE, drive in_ready_o=out_ready_i; on out_ready_i with in_valid_i it captures new data and enters BUSY, and on out_ready_i without in_valid_i it enters IDLE.
REQ-020 SHALL ignore in_valid_i and X_i while in BUSY (in_ready_o=0).
REQ-021 SHALL hold out_valid_o and Y_o unchanged while out_ready_i=0 (back-pressure).
REQ-022 SHALL hold working data when in_valid_i is deasserted in IDLE and never produce a spurious out_valid_o.

Reset
REQ-023 SHALL, on rst_i=1 at any time including mid-BUSY, immediately force state IDLE, counter 0, working register 0, out_valid_o=0, in_ready_o=0 while asserted, and discard the in-flight transaction.
REQ-024 SHALL raise in_ready_o in the first cycle after rst_i deasserts.

Structure
REQ-025 SHALL place the 256-entry S-box table constant, the FSM state enum and the CYC/counter-width helper function in shared package sm4_pkg.
REQ-026 SHALL instantiate N_SBOX copies of one combinational sub-module sm4_sbox_lut (8-bit in, 8-bit out, table from sm4_pkg).
REQ-027 SHALL select group inputs to sm4_sbox_lut through a counter-indexed multiplexer, with no other per-byte logic.

Verification
REQ-028 SHALL cover: defaults, X_i=0x00010203 -> Y_o=0xD690E9FE, with out_valid_o 2 cycles after accept.
REQ-029 SHALL cover: X_i=0xFFAB0000 -> Y_o=0x48ABD6D6 (fixed point 0xAB->0xAB checked).
REQ-030 SHALL cover: WORDS=2, N_SBOX=1, X_i=0x00000000_FFFFFFFF -> Y_o=0xD6D6D6D6_48484848, in_ready_o=0 for 8 BUSY cycles, out_valid_o 9 cycles after accept.
REQ-031 SHALL cover: out_ready_i held 0 for 5 cycles in DONE -> Y_o stable, out_valid_o=1 throughout; then out_ready_i=1 with in_valid_i=1 -> back-to-back accept, next result correct.
REQ-032 SHALL cover: rst_i pulsed at BUSY cycle 3 of 8 (WORDS=2, N_SBOX=1) -> out_valid_o never rises, next transaction yields the correct result.
REQ-033 SHALL cover: exhaustive sweep of all 256 byte values in lane 0 against a sm4_pkg reference model, for N_SBOX in {1,2,4}.

Source files
------------

// File: rtl/sm4_pkg.sv
// SM4 byte substitution shared definitions.
// S-box table, engine states and group-count helpers.
package sm4_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [7:0] SBOX [256] = '{
        8'hD6, 8'h90, 8'hE9, 8'hFE, 8'hCC, 8'hE1, 8'h3D, 8'hB7,
        8'h16, 8'hB6, 8'h14, 8'hC2, 8'h28, 8'hFB, 8'h2C, 8'h05,
        8'h2B, 8'h67, 8'h9A, 8'h76, 8'h2A, 8'hBE, 8'h04, 8'hC3,
        8'hAA, 8'h44, 8'h13, 8'h26, 8'h49, 8'h86, 8'h06, 8'h99,
        8'h9C, 8'h42, 8'h50, 8'hF4, 8'h91, 8'hEF, 8'h98, 8'h7A,
        8'h33, 8'h54, 8'h0B, 8'h43, 8'hED, 8'hCF, 8'hAC, 8'h62,
        8'hE4, 8'hB3, 8'h1C, 8'hA9, 8'hC9, 8'h08, 8'hE8, 8'h95,
        8'h80, 8'hDF, 8'h94, 8'hFA, 8'h75, 8'h8F, 8'h3F, 8'hA6,
        8'h47, 8'h07, 8'hA7, 8'hFC, 8'hF3, 8'h73, 8'h17, 8'hBA,
        8'h83, 8'h59, 8'h3C, 8'h19, 8'hE6, 8'h85, 8'h4F, 8'hA8,
        8'h68, 8'h6B, 8'h81, 8'hB2, 8'h71, 8'h64, 8'hDA, 8'h8B,
        8'hF8, 8'hEB, 8'h0F, 8'h4B, 8'h70, 8'h56, 8'h9D, 8'h35,
        8'h1E, 8'h24, 8'h0E, 8'h5E, 8'h63, 8'h58, 8'hD1, 8'hA2,
        8'h25, 8'h22, 8'h7C, 8'h3B, 8'h01, 8'h21, 8'h78, 8'h87,
        8'hD4, 8'h00, 8'h46, 8'h57, 8'h9F, 8'hD3, 8'h27, 8'h52,
        8'h4C, 8'h36, 8'h02, 8'hE7, 8'hA0, 8'hC4, 8'hC8, 8'h9E,
        8'hEA, 8'hBF, 8'h8A, 8'hD2, 8'h40, 8'hC7, 8'h38, 8'hB5,
        8'hA3, 8'hF7, 8'hF2, 8'hCE, 8'hF9, 8'h61, 8'h15, 8'hA1,
        8'hE0, 8'hAE, 8'h5D, 8'hA4, 8'h9B, 8'h34, 8'h1A, 8'h55,
        8'hAD, 8'h93, 8'h32, 8'h30, 8'hF5, 8'h8C, 8'hB1, 8'hE3,
        8'h1D, 8'hF6, 8'hE2, 8'h2E, 8'h82, 8'h66, 8'hCA, 8'h60,
        8'hC0, 8'h29, 8'h23, 8'hAB, 8'h0D, 8'h53, 8'h4E, 8'h6F,
        8'hD5, 8'hDB, 8'h37, 8'h45, 8'hDE, 8'hFD, 8'h8E, 8'h2F,
        8'h03, 8'hFF, 8'h6A, 8'h72, 8'h6D, 8'h6C, 8'h5B, 8'h51,
        8'h8D, 8'h1B, 8'hAF, 8'h92, 8'hBB, 8'hDD, 8'hBC, 8'h7F,
        8'h11, 8'hD9, 8'h5C, 8'h41, 8'h1F, 8'h10, 8'h5A, 8'hD8,
        8'h0A, 8'hC1, 8'h31, 8'h88, 8'hA5, 8'hCD, 8'h7B, 8'hBD,
        8'h2D, 8'h74, 8'hD0, 8'h12, 8'hB8, 8'hE5, 8'hB4, 8'hB0,
        8'h89, 8'h69, 8'h97, 8'h4A, 8'h0C, 8'h96, 8'h77, 8'h7E,
        8'h65, 8'hB9, 8'hF1, 8'h09, 8'hC5, 8'h6E, 8'hC6, 8'h84,
        8'h18, 8'hF0, 8'h7D, 8'hEC, 8'h3A, 8'hDC, 8'h4D, 8'h20,
        8'h79, 8'hEE, 8'h5F, 8'h3E, 8'hD7, 8'hCB, 8'h39, 8'h48
    };

    // Number of BUSY cycles needed to cover every byte.
    function automatic int calc_cyc(int words, int n_sbox);
        return (4 * words) / n_sbox;
    endfunction

    // Group counter width, never narrower than one bit.
    function automatic int calc_cnt_w(int cyc);
        return (cyc <= 1) ? 1 : $clog2(cyc);
    endfunction

endpackage

// File: rtl/sm4_sbox_lut.sv
// One combinational SM4 S-box lane.
// Pure table lookup, 8 bits in and 8 bits out.
module sm4_sbox_lut
    import sm4_pkg::*;
(
    input  logic [7:0] i_byte,
    output logic [7:0] o_byte
);

    assign o_byte = SBOX[i_byte];

endmodule

// File: rtl/sm4_tau_engine.sv
// SM4 tau engine: byte-wise S-box over WORDS words.
// N_SBOX lanes are time-shared across CYC byte groups.
module sm4_tau_engine
    import sm4_pkg::*;
#(
    parameter int WORDS  = 1,
    parameter int N_SBOX = 4
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    input  logic [32*WORDS-1:0] X_i,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic [32*WORDS-1:0] Y_o
);

    localparam int NB  = 4 * WORDS;
    localparam int CYC = calc_cyc(WORDS, N_SBOX);
    localparam int CW  = calc_cnt_w(CYC);
    localparam logic [CW-1:0] LAST = CW'(CYC - 1);

    state_t          r_state;
    state_t          w_next;
    logic [CW-1:0]   r_cnt;
    logic [8*NB-1:0] r_work;
    logic            w_load;
    logic            w_step;
    logic [7:0]      w_sin  [N_SBOX];
    logic [7:0]      w_sout [N_SBOX];

    // Pick the byte group addressed by the counter (byte 0 is the MSB).
    always_comb begin
        for (int j = 0; j < N_SBOX; j++) begin
            w_sin[j] = r_work[8*(NB-1-(int'(r_cnt)*N_SBOX+j)) +: 8];
        end
    end

    for (genvar g = 0; g < N_SBOX; g++) begin : g_lane
        sm4_sbox_lut u_lut (
            .i_byte (w_sin[g]),
            .o_byte (w_sout[g])
        );
    end

    // Next-state, handshake and datapath-control decode.
    always_comb begin
        w_next      = r_state;
        w_load      = 1'b0;
        w_step      = 1'b0;
        in_ready_o  = 1'b0;
        out_valid_o = 1'b0;
        unique case (r_state)
            IDLE: begin
                in_ready_o = ~rst_i;
                if (in_valid_i) begin
                    w_load = 1'b1;
                    w_next = BUSY;
                end
            end
            BUSY: begin
                w_step = 1'b1;
                if (r_cnt == LAST) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                out_valid_o = 1'b1;
                in_ready_o  = out_ready_i;
                if (out_ready_i) begin
                    if (in_valid_i) begin
                        w_load = 1'b1;
                        w_next = BUSY;
                    end else begin
                        w_next = IDLE;
                    end
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // State register; reset abandons any in-flight transaction.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Working register: load on accept, substitute one group per BUSY cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cnt  <= '0;
            r_work <= '0;
        end else if (w_load) begin
            r_cnt  <= '0;
            r_work <= X_i;
        end else if (w_step) begin
            for (int j = 0; j < N_SBOX; j++) begin
                r_work[8*(NB-1-(int'(r_cnt)*N_SBOX+j)) +: 8] <= w_sout[j];
            end
            r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
        end
    end

    assign Y_o = r_work;

endmodule

// File: tb/tb_sm4_tau_engine.sv
// Scoreboard bench for sm4_tau_engine in three configurations.
// d0: WORDS=1,N_SBOX=4  d1: WORDS=2,N_SBOX=1  d2: WORDS=1,N_SBOX=2
module tb_sm4_tau_engine;
    import sm4_pkg::*;

    typedef struct {
        logic [63:0] y;
        int          acc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  iv;
    logic [2:0]  ordy;
    wire  [2:0]  ir;
    wire  [2:0]  ov;
    logic [31:0] x0;
    logic [63:0] x1;
    logic [31:0] x2;
    wire  [31:0] y0;
    wire  [63:0] y1;
    wire  [31:0] y2;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int rdy_ctl [3];

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    logic [2:0]   pv;
    logic [2:0]   pr;
    logic [63:0]  cur  [3];
    logic [255:0] seen [3];
    bit           sweep_on;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    sm4_tau_engine #(.WORDS(1), .N_SBOX(4)) u_d0 (
        .clk_i(clk), .rst_i(rst),
        .in_valid_i(iv[0]), .in_ready_o(ir[0]), .X_i(x0),
        .out_valid_o(ov[0]), .out_ready_i(ordy[0]), .Y_o(y0)
    );
    sm4_tau_engine #(.WORDS(2), .N_SBOX(1)) u_d1 (
        .clk_i(clk), .rst_i(rst),
        .in_valid_i(iv[1]), .in_ready_o(ir[1]), .X_i(x1),
        .out_valid_o(ov[1]), .out_ready_i(ordy[1]), .Y_o(y1)
    );
    sm4_tau_engine #(.WORDS(1), .N_SBOX(2)) u_d2 (
        .clk_i(clk), .rst_i(rst),
        .in_valid_i(iv[2]), .in_ready_o(ir[2]), .X_i(x2),
        .out_valid_o(ov[2]), .out_ready_i(ordy[2]), .Y_o(y2)
    );

    function automatic int words_of(int d);
        return (d == 1) ? 2 : 1;
    endfunction

    function automatic int cyc_of(int d);
        return (d == 0) ? 1 : ((d == 1) ? 8 : 2);
    endfunction

    function automatic logic [63:0] yget(int d);
        case (d)
            0:       return {32'h0, y0};
            1:       return y1;
            default: return {32'h0, y2};
        endcase
    endfunction

    function automatic logic [7:0] lane0(int d, logic [63:0] v);
        return (d == 1) ? v[63:56] : v[31:24];
    endfunction

    // Reference: every byte goes through the S-box on its own.
    function automatic logic [63:0] ref_sub(logic [63:0] v, int words);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < 4 * words; i++) begin
            r[i*8 +: 8] = SBOX[v[i*8 +: 8]];
        end
        return r;
    endfunction

    function automatic void push(int d, exp_t e);
        case (d)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endfunction

    function automatic int qsize(int d);
        case (d)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    function automatic exp_t pop(int d);
        exp_t e;
        case (d)
            0:       e = q0.pop_front();
            1:       e = q1.pop_front();
            default: e = q2.pop_front();
        endcase
        return e;
    endfunction

    task automatic check(string nm, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic setx(int d, logic [63:0] v);
        case (d)
            0:       x0 = v[31:0];
            1:       x1 = v;
            default: x2 = v[31:0];
        endcase
    endtask

    // Offer one transaction; the expectation is queued at the accept edge.
    task automatic send(int d, logic [63:0] v, logic [63:0] exp);
        int   n;
        exp_t e;
        n = 0;
        setx(d, v);
        iv[d] = 1'b1;
        @(negedge clk);
        while (!ir[d] && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!ir[d]) begin
            check("accept_timeout", 64'(ir[d]), 64'd1);
        end else begin
            e.y   = exp;
            e.acc = cyc + 1;
            push(d, e);
        end
        tick();
        iv[d] = 1'b0;
    endtask

    function automatic logic [63:0] rand_data(int d);
        logic [63:0] v;
        v = {$urandom, $urandom};
        if (words_of(d) == 1) v[63:32] = '0;
        return v;
    endfunction

    // Downstream ready: 0 = stall, 1 = always ready, 2 = random.
    always begin
        @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            if (rdy_ctl[d] == 2) ordy[d] = ($urandom_range(0, 2) != 0);
            else                 ordy[d] = (rdy_ctl[d] == 1);
        end
    end

    // Monitor: compares each new result and polices back-pressure.
    always @(negedge clk) begin
        exp_t        e;
        logic [63:0] yv;
        if (rst) begin
            pv <= '0;
            pr <= '0;
        end else begin
            for (int d = 0; d < 3; d++) begin
                yv = yget(d);
                if (pv[d] && pr[d]) begin
                    check("valid_after_handshake", 64'(ov[d]), 64'd0);
                end else if (pv[d] && !pr[d]) begin
                    check("hold_valid", 64'(ov[d]), 64'd1);
                    check("hold_data", yv, cur[d]);
                end else if (ov[d]) begin
                    if (qsize(d) == 0) begin
                        check("unexpected_output", 64'(ov[d]), 64'd0);
                    end else begin
                        e = pop(d);
                        check("result", yv, e.y);
                        check("latency", 64'(cyc - e.acc), 64'(cyc_of(d)));
                    end
                    cur[d] <= yv;
                    if (sweep_on) seen[d][lane0(d, yv)] <= 1'b1;
                end
                pv[d] <= ov[d];
                pr[d] <= ordy[d];
            end
        end
    end

    initial begin
        int          n;
        bit          flag;
        logic [63:0] v;

        rst      = 1'b1;
        iv       = '0;
        x0       = '0;
        x1       = '0;
        x2       = '0;
        sweep_on = 1'b0;
        for (int d = 0; d < 3; d++) begin
            rdy_ctl[d] = 1;
            seen[d]    = '0;
            cur[d]     = '0;
        end

        repeat (3) @(negedge clk);
        check("rst_in_ready", 64'(ir), 64'd0);
        check("rst_out_valid", 64'(ov), 64'd0);
        check("rst_y1", y1, 64'd0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        @(negedge clk);
        check("in_ready_after_rst", 64'(ir), 64'd7);

        // Known answers, second one back-to-back with the first.
        tick();
        send(0, 64'h00010203, 64'hD690E9FE);
        send(0, 64'hFFAB0000, 64'h48ABD6D6);
        repeat (6) tick();
        check("idle_hold_y", {32'h0, y0}, 64'h48ABD6D6);
        check("idle_no_valid", 64'(ov[0]), 64'd0);

        // Eight single-lane BUSY cycles with input stalled.
        send(1, 64'h00000000_FFFFFFFF, 64'hD6D6D6D6_48484848);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("busy_in_ready", 64'(ir[1]), 64'd0);
        end
        repeat (4) tick();

        // Back-pressure, then release together with a new input.
        rdy_ctl[0] = 0;
        tick();
        send(0, 64'h01234567, ref_sub(64'h01234567, 1));
        n = 0;
        while (!ov[0] && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("bp_valid_seen", 64'(ov[0]), 64'd1);
        repeat (5) @(negedge clk);
        check("bp_valid_held", 64'(ov[0]), 64'd1);
        rdy_ctl[0] = 1;
        tick();
        v = rand_data(0);
        send(0, v, ref_sub(v, 1));
        repeat (5) tick();

        // Reset in BUSY cycle 3 of 8 drops the transaction.
        v = rand_data(1);
        send(1, v, ref_sub(v, 2));
        repeat (2) tick();
        rst = 1'b1;
        #1;
        check("midrst_valid", 64'(ov[1]), 64'd0);
        check("midrst_ready", 64'(ir[1]), 64'd0);
        check("midrst_y", y1, 64'd0);
        q1.delete();
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("midrst_ready_after", 64'(ir[1]), 64'd1);
        flag = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (ov[1]) flag = 1'b1;
        end
        check("midrst_no_valid", 64'(flag), 64'd0);
        tick();
        v = rand_data(1);
        send(1, v, ref_sub(v, 2));
        repeat (12) tick();

        // Every byte value through lane 0 of each configuration.
        sweep_on = 1'b1;
        for (int d = 0; d < 3; d++) begin
            for (int b = 0; b < 256; b++) begin
                v = rand_data(d);
                if (d == 1) v[63:56] = 8'(b);
                else        v[31:24] = 8'(b);
                send(d, v, ref_sub(v, words_of(d)));
            end
        end
        repeat (20) tick();
        sweep_on = 1'b0;
        for (int d = 0; d < 3; d++) begin
            check("lane0_permutation", 64'($countones(seen[d])), 64'd256);
        end

        // Random data with random downstream stalls.
        for (int d = 0; d < 3; d++) rdy_ctl[d] = 2;
        for (int d = 0; d < 3; d++) begin
            for (int i = 0; i < 40; i++) begin
                v = rand_data(d);
                send(d, v, ref_sub(v, words_of(d)));
                repeat ($urandom_range(0, 3)) tick();
            end
        end
        n = 0;
        while ((q0.size() + q1.size() + q2.size()) != 0 && n < 500) begin
            tick();
            n++;
        end
        check("drain", 64'(q0.size() + q1.size() + q2.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
